// File: rtl/sync_fifo_lvl_pkg.sv
// Shared helpers for the sync_fifo_lvl slice: depth/level-width sizing and
// threshold comparisons used for the almost-full/almost-empty flags.
package fifo_pkg;

  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

  function automatic int lvl_width(input int asize);
    return asize + 1;
  endfunction

  function automatic logic lvl_ge(input int lvl, input int thr);
    return lvl >= thr;
  endfunction

  function automatic logic lvl_le(input int lvl, input int thr);
    return lvl <= thr;
  endfunction

endpackage

// File: rtl/sync_fifo_lvl_dualram.sv
// Simple dual-port storage for sync_fifo_lvl: registered write, asynchronous
// read. Contents are never reset.
module dualram
  import fifo_pkg::*;
#(
  parameter int ASIZE = 3,
  parameter int DSIZE = 32
) (
  input  logic             i_we,
  input  logic             i_clk,
  input  logic [ASIZE-1:0] i_wr_addr,
  input  logic [ASIZE-1:0] i_rd_addr,
  input  logic [DSIZE-1:0] i_data,
  output logic [DSIZE-1:0] o_data
);

  localparam int DEPTH = fifo_depth(ASIZE);

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_wr_addr] <= i_data;
    end
  end

  assign o_data = mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with occupancy level and programmable almost flags.
// Define SYNC_FIFO_ERR_EN to build the sticky ovf/udf error flags.
module sync_fifo_lvl
  import fifo_pkg::*;
#(
  parameter int ASIZE    = 3,
  parameter int DSIZE    = 32,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wreq,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rreq,
  output logic [DSIZE-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   level,
  output logic             ovf,
  output logic             udf
);

  localparam int DEPTH = fifo_depth(ASIZE);
  localparam int LW    = lvl_width(ASIZE);
  localparam logic [ASIZE:0] ONE = LW'(1);

  logic [ASIZE:0]   waddr_q, waddr_d, raddr_q, raddr_d, level_q, level_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             af_q, af_d, ae_q, ae_d;
  logic [DSIZE-1:0] rdata_q, rdata_d, ram_rdata;
  logic             wr_acc, rd_acc;

  // Acceptance looks only at registered flags, so no input-to-flag paths exist.
  assign wr_acc = wreq & ~full_q;
  assign rd_acc = rreq & ~empty_q;

  dualram #(.ASIZE(ASIZE), .DSIZE(DSIZE)) u_ram (
    .i_we      (wr_acc),
    .i_clk     (clk),
    .i_wr_addr (waddr_q[ASIZE-1:0]),
    .i_rd_addr (raddr_q[ASIZE-1:0]),
    .i_data    (wdata),
    .o_data    (ram_rdata)
  );

  always_comb begin
    waddr_d = wr_acc ? waddr_q + ONE : waddr_q;
    raddr_d = rd_acc ? raddr_q + ONE : raddr_q;
    rdata_d = rd_acc ? ram_rdata : rdata_q;
    level_d = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + ONE;
      2'b01:   level_d = level_q - ONE;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
    af_d    = lvl_ge(int'(level_d), AF_LEVEL);
    ae_d    = lvl_le(int'(level_d), AE_LEVEL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waddr_q <= '0;
      raddr_q <= '0;
      level_q <= '0;
      rdata_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      level_q <= level_d;
      rdata_q <= rdata_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
    end
  end

  assign rdata        = rdata_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign level        = level_q;

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, udf_q;

  // Sticky until reset: any rejected request is remembered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wreq && full_q)  ovf_q <= 1'b1;
      if (rreq && empty_q) udf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Scoreboard bench for sync_fifo_lvl: two instances (default thresholds and
// AF=4/AE=2) share one stimulus stream and are checked against a queue model.
module tb_sync_fifo_lvl;

  localparam int DEPTH = 8;
  localparam int AF1 = 6, AE1 = 1, AF2 = 4, AE2 = 2;

  typedef struct packed {
    logic [3:0]  lvl;
    logic        full, empty, af, ae, af2, ae2, ovf, udf;
    logic [31:0] rd;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1, wreq = 1'b0, rreq = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata, rdata2;
  logic        full, empty, almostFull, almostEmpty, ovf, udf;
  logic        full2, empty2, almostFull2, almostEmpty2, ovf2, udf2;
  logic [3:0]  level, level2;

  logic [31:0] modelQ[$];
  exp_t        expQ[$];
  logic [31:0] lastRd = '0;
  logic        ovfM = 1'b0, udfM = 1'b0;
  int          nCompared = 0, nMismatched = 0;

  sync_fifo_lvl #(.ASIZE(3), .DSIZE(32), .AF_LEVEL(AF1), .AE_LEVEL(AE1)) u_dut (
    .clk(clk), .rst(rst), .wreq(wreq), .wdata(wdata), .rreq(rreq),
    .rdata(rdata), .full(full), .empty(empty), .almost_full(almostFull),
    .almost_empty(almostEmpty), .level(level), .ovf(ovf), .udf(udf)
  );

  sync_fifo_lvl #(.ASIZE(3), .DSIZE(32), .AF_LEVEL(AF2), .AE_LEVEL(AE2)) u_dut2 (
    .clk(clk), .rst(rst), .wreq(wreq), .wdata(wdata), .rreq(rreq),
    .rdata(rdata2), .full(full2), .empty(empty2), .almost_full(almostFull2),
    .almost_empty(almostEmpty2), .level(level2), .ovf(ovf2), .udf(udf2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word queue plus the spec's rules; expected state is queued per cycle.
  task automatic applyStimulus(input logic w, input logic [31:0] d, input logic r);
    bit   wAcc, rAcc;
    int   n;
    exp_t e;
    @(negedge clk);
    wreq = w; wdata = d; rreq = r;
    wAcc = w && (modelQ.size() < DEPTH);
    rAcc = r && (modelQ.size() > 0);
`ifdef SYNC_FIFO_ERR_EN
    if (w && modelQ.size() == DEPTH) ovfM = 1'b1;
    if (r && modelQ.size() == 0)     udfM = 1'b1;
`endif
    @(posedge clk);
    if (rAcc) lastRd = modelQ.pop_front();
    if (wAcc) modelQ.push_back(d);
    n       = modelQ.size();
    e.lvl   = 4'(n);
    e.full  = (n == DEPTH);
    e.empty = (n == 0);
    e.af    = (n >= AF1);
    e.ae    = (n <= AE1);
    e.af2   = (n >= AF2);
    e.ae2   = (n <= AE2);
    e.ovf   = ovfM;
    e.udf   = udfM;
    e.rd    = lastRd;
    expQ.push_back(e);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rdata"}, rdata, 32'h0);
    checkOutput({tag, "_level"}, 32'(level), 32'h0);
    checkOutput({tag, "_full"}, 32'(full), 32'h0);
    checkOutput({tag, "_empty"}, 32'(empty), 32'h1);
    checkOutput({tag, "_af"}, 32'(almostFull), 32'h0);
    checkOutput({tag, "_ae"}, 32'(almostEmpty), 32'h1);
    checkOutput({tag, "_ae2"}, 32'(almostEmpty2), 32'h1);
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'h0);
    checkOutput({tag, "_udf"}, 32'(udf), 32'h0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #1 rst = 1'b0;
    wreq = 1'b0; rreq = 1'b0;
    #1 checkResetValues("midreset");
    modelQ.delete();
    lastRd = '0; ovfM = 1'b0; udfM = 1'b0;
    #1 rst = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("level", 32'(level), 32'(e.lvl));
        checkOutput("full", 32'(full), 32'(e.full));
        checkOutput("empty", 32'(empty), 32'(e.empty));
        checkOutput("almost_full", 32'(almostFull), 32'(e.af));
        checkOutput("almost_empty", 32'(almostEmpty), 32'(e.ae));
        checkOutput("rdata", rdata, e.rd);
        checkOutput("ovf", 32'(ovf), 32'(e.ovf));
        checkOutput("udf", 32'(udf), 32'(e.udf));
        checkOutput("level_b", 32'(level2), 32'(e.lvl));
        checkOutput("almost_full_b", 32'(almostFull2), 32'(e.af2));
        checkOutput("almost_empty_b", 32'(almostEmpty2), 32'(e.ae2));
        checkOutput("rdata_b", rdata2, e.rd);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    #2 rst = 1'b0;
    #2 checkResetValues("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'hA0 + 32'(i), 1'b0);
    applyStimulus(1'b1, 32'hFF, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, $urandom, 1'b1);

    for (int i = 0; i < 2; i++) applyStimulus(1'b1, $urandom, 1'b0);
    pulseReset();
    applyStimulus(1'b1, 32'h5EED_0001, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);

    for (int i = 0; i < 200; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0);
    for (int i = 0; i < 200; i++)
      applyStimulus($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 200; i++)
      applyStimulus($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1);

    @(negedge clk);
    wreq = 1'b0; rreq = 1'b0;
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
